// File: rtl/alarm_reader.sv
// alarm_reader
// Read side of the weekly alarm store. On every second tick it picks the
// alarm word for the current day, compares it against the time of day and
// starts the ringer on a match. It also handles the ring timeout and, when
// built with ALARM_SNOOZE_EN defined, the snooze sequencing.
//
// Build option:
//   ALARM_SNOOZE_EN  defined     -> snooze input, SNOOZE state and snooze
//                                   counter are present
//                    not defined -> snooze is ignored; snoozing and
//                                   snooze_cnt are tied to 0
//
// Ports:
//   Clk         system clock, rising edge
//   CLR         asynchronous active-low clear
//   Q_r0..Q_r6  alarm words Sunday..Saturday: [12] armed, [11] unused,
//               [10:6] hour, [5:0] minute
//   day         current day 0..6; 7 is invalid and never matches
//   cur_hour    current hour
//   cur_min     current minute
//   cur_sec     current second
//   sec_tick    one-cycle pulse per second; time inputs valid in that cycle
//   stop        level, ends a ring or a snooze
//   snooze      level, moves a ring into snooze
//   ring        buzzer drive, high exactly while ringing
//   snoozing    high exactly while snoozing
//   snooze_cnt  snoozes used in the current alarm event

module alarm_reader #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        Clk,
    input  logic        CLR,
    input  logic [12:0] Q_r0,
    input  logic [12:0] Q_r1,
    input  logic [12:0] Q_r2,
    input  logic [12:0] Q_r3,
    input  logic [12:0] Q_r4,
    input  logic [12:0] Q_r5,
    input  logic [12:0] Q_r6,
    input  logic [2:0]  day,
    input  logic [4:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic [5:0]  cur_sec,
    input  logic        sec_tick,
    input  logic        stop,
    input  logic        snooze,
    output logic        ring,
    output logic        snoozing,
    output logic [1:0]  snooze_cnt
);

    // The second counter holds the "seconds spent" in the current state;
    // terminal values are stored as count-1 so the compare uses the value
    // before the increment.
    localparam logic [9:0] RING_LAST = 10'(RING_SECS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RINGING
`ifdef ALARM_SNOOZE_EN
        ,
        SNOOZE
`endif
    } state_t;

    state_t      state;
    logic [9:0]  sec_cnt;
    logic [12:0] sel_word;
    logic        match;
    logic        unused_bits;

    // Day selection; the invalid day 7 selects an all-zero word, which is
    // never armed and so can never match.
    always_comb begin
        sel_word = 13'd0;
        case (day)
            3'd0:    sel_word = Q_r0;
            3'd1:    sel_word = Q_r1;
            3'd2:    sel_word = Q_r2;
            3'd3:    sel_word = Q_r3;
            3'd4:    sel_word = Q_r4;
            3'd5:    sel_word = Q_r5;
            3'd6:    sel_word = Q_r6;
            default: sel_word = 13'd0;
        endcase
    end

    assign match = sel_word[12]
                && (sel_word[10:6] == cur_hour)
                && (sel_word[5:0]  == cur_min)
                && (cur_sec == 6'd0);

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
    localparam logic [1:0] MAX_CNT     = 2'(MAX_SNOOZE);

    assign unused_bits = sel_word[11];
`else
    assign unused_bits = sel_word[11] ^ snooze
                       ^ (SNOOZE_SECS == 0) ^ (MAX_SNOOZE == 0);
    assign snoozing    = 1'b0;
    assign snooze_cnt  = 2'd0;
`endif

    // Main sequencer. ring and snoozing are registered alongside the state
    // so they are pure decodes of it. stop is tested first everywhere, so a
    // stop coinciding with snooze or a sec_tick always wins.
    always_ff @(posedge Clk or negedge CLR) begin
        if (!CLR) begin
            state      <= IDLE;
            sec_cnt    <= 10'd0;
            ring       <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozing   <= 1'b0;
            snooze_cnt <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sec_tick && match) begin
                        state      <= RINGING;
                        sec_cnt    <= 10'd0;
                        ring       <= 1'b1;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt <= 2'd0;
`endif
                    end
                end

                RINGING: begin
                    if (stop) begin
                        state      <= IDLE;
                        sec_cnt    <= 10'd0;
                        ring       <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt <= 2'd0;
`endif
                    end
`ifdef ALARM_SNOOZE_EN
                    // Once the snooze allowance is used up a further snooze
                    // request ends the event like a stop.
                    else if (snooze) begin
                        sec_cnt <= 10'd0;
                        ring    <= 1'b0;
                        if (snooze_cnt < MAX_CNT) begin
                            state      <= SNOOZE;
                            snoozing   <= 1'b1;
                            snooze_cnt <= snooze_cnt + 2'd1;
                        end else begin
                            state      <= IDLE;
                            snooze_cnt <= 2'd0;
                        end
                    end
`endif
                    else if (sec_tick) begin
                        if (sec_cnt == RING_LAST) begin
                            state   <= IDLE;
                            sec_cnt <= 10'd0;
                            ring    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                            snooze_cnt <= 2'd0;
`endif
                        end else begin
                            sec_cnt <= sec_cnt + 10'd1;
                        end
                    end
                end

`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop) begin
                        state      <= IDLE;
                        sec_cnt    <= 10'd0;
                        snoozing   <= 1'b0;
                        snooze_cnt <= 2'd0;
                    end else if (sec_tick) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            state    <= RINGING;
                            sec_cnt  <= 10'd0;
                            ring     <= 1'b1;
                            snoozing <= 1'b0;
                        end else begin
                            sec_cnt <= sec_cnt + 10'd1;
                        end
                    end
                end
`endif

                default: begin
                    state   <= IDLE;
                    sec_cnt <= 10'd0;
                    ring    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    snoozing   <= 1'b0;
                    snooze_cnt <= 2'd0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_reader.sv
// Testbench for alarm_reader with default parameters (RING_SECS=60,
// SNOOZE_SECS=300, MAX_SNOOZE=3). Snooze scenarios follow whichever build of
// ALARM_SNOOZE_EN the design was compiled with.

module tb_alarm_reader;

    logic        Clk = 1'b0;
    logic        CLR = 1'b0;
    logic [12:0] Q_r0 = 13'd0, Q_r1 = 13'd0, Q_r2 = 13'd0, Q_r3 = 13'd0;
    logic [12:0] Q_r4 = 13'd0, Q_r5 = 13'd0, Q_r6 = 13'd0;
    logic [2:0]  day = 3'd0;
    logic [4:0]  cur_hour = 5'd0;
    logic [5:0]  cur_min = 6'd0;
    logic [5:0]  cur_sec = 6'd0;
    logic        sec_tick = 1'b0;
    logic        stop = 1'b0;
    logic        snooze = 1'b0;
    logic        ring;
    logic        snoozing;
    logic [1:0]  snooze_cnt;

    int checks = 0;
    int errors = 0;

    // 07:30 armed alarm word
    localparam logic [12:0] ALARM_0730 = 13'h11DE;

    alarm_reader dut (
        .Clk        (Clk),
        .CLR        (CLR),
        .Q_r0       (Q_r0),
        .Q_r1       (Q_r1),
        .Q_r2       (Q_r2),
        .Q_r3       (Q_r3),
        .Q_r4       (Q_r4),
        .Q_r5       (Q_r5),
        .Q_r6       (Q_r6),
        .day        (day),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .sec_tick   (sec_tick),
        .stop       (stop),
        .snooze     (snooze),
        .ring       (ring),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock cycle with sec_tick at the given level; outputs settle
    // 1 time unit after the edge.
    task automatic step(input logic t);
        sec_tick = t;
        @(posedge Clk);
        #1;
        sec_tick = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    task automatic start_ring();
        Q_r3 = ALARM_0730;
        day  = 3'd3;
        set_time(7, 30, 0);
        step(1'b1);
        set_time(7, 30, 1);
    endtask

    task automatic stop_ring();
        stop = 1'b1;
        step(1'b0);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ring: got %b expected 0", ring);
        end
        checks++;
        if (snoozing !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_snoozing: got %b expected 0", snoozing);
        end
        checks++;
        if (snooze_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_snooze_cnt: got %0d expected 0", snooze_cnt);
        end
        @(posedge Clk);
        #1;
        CLR = 1'b1;
        step(1'b0);
    endtask

    task automatic test_match();
        Q_r2 = ALARM_0730;
        day  = 3'd2;
        set_time(7, 30, 0);
        step(1'b1);
        checks++;
        if (ring !== 1'b1) begin
            errors++;
            $display("[TB] FAIL match_ring: got %b expected 1", ring);
        end
        stop_ring();
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_ring: got %b expected 0", ring);
        end
        set_time(7, 30, 1);
        step(1'b1);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nonzero_sec: got %b expected 0", ring);
        end
        Q_r2 = 13'h01DE;
        set_time(7, 30, 0);
        step(1'b1);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disarmed: got %b expected 0", ring);
        end
        Q_r2 = ALARM_0730;
        step(1'b0);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_tick: got %b expected 0", ring);
        end
    endtask

    task automatic test_day();
        Q_r2 = ALARM_0730;
        Q_r3 = 13'd0;
        set_time(7, 30, 0);
        day = 3'd3;
        step(1'b1);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrong_day: got %b expected 0", ring);
        end
        day = 3'd7;
        Q_r0 = ALARM_0730;
        Q_r6 = ALARM_0730;
        step(1'b1);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL day7: got %b expected 0", ring);
        end
        Q_r0 = 13'd0;
        Q_r6 = 13'd0;
        Q_r3 = ALARM_0730 | 13'h0800;
        day  = 3'd3;
        step(1'b1);
        checks++;
        if (ring !== 1'b1) begin
            errors++;
            $display("[TB] FAIL day3_ring: got %b expected 1", ring);
        end
        stop_ring();
    endtask

    task automatic test_autostop();
        start_ring();
        for (int i = 0; i < 59; i++) begin
            step(1'b1);
            step(1'b0);
        end
        checks++;
        if (ring !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ring_59_ticks: got %b expected 1", ring);
        end
        step(1'b1);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL autostop: got %b expected 0", ring);
        end
        set_time(7, 31, 0);
        step(1'b1);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL retrigger_0731: got %b expected 0", ring);
        end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        start_ring();
        for (int n = 1; n <= 3; n++) begin
            snooze = 1'b1;
            step(1'b0);
            snooze = 1'b0;
            checks++;
            if (ring !== 1'b0 || snoozing !== 1'b1 || snooze_cnt !== 2'(n)) begin
                errors++;
                $display("[TB] FAIL snooze_enter: got ring=%b snoozing=%b cnt=%0d expected ring=0 snoozing=1 cnt=%0d",
                         ring, snoozing, snooze_cnt, n);
            end
            snooze = 1'b1;
            step(1'b1);
            snooze = 1'b0;
            for (int i = 1; i < 299; i++) step(1'b1);
            checks++;
            if (snoozing !== 1'b1 || ring !== 1'b0) begin
                errors++;
                $display("[TB] FAIL snooze_299: got ring=%b snoozing=%b expected ring=0 snoozing=1",
                         ring, snoozing);
            end
            step(1'b1);
            checks++;
            if (ring !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 2'(n)) begin
                errors++;
                $display("[TB] FAIL snooze_expire: got ring=%b snoozing=%b cnt=%0d expected ring=1 snoozing=0 cnt=%0d",
                         ring, snoozing, snooze_cnt, n);
            end
        end
        snooze = 1'b1;
        step(1'b0);
        snooze = 1'b0;
        checks++;
        if (ring !== 1'b0 || snoozing !== 1'b0 || snooze_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL fourth_snooze: got ring=%b snoozing=%b cnt=%0d expected 0 0 0",
                     ring, snoozing, snooze_cnt);
        end
        start_ring();
        snooze = 1'b1;
        step(1'b0);
        snooze = 1'b0;
        stop = 1'b1;
        step(1'b1);
        stop = 1'b0;
        checks++;
        if (ring !== 1'b0 || snoozing !== 1'b0 || snooze_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stop_in_snooze: got ring=%b snoozing=%b cnt=%0d expected 0 0 0",
                     ring, snoozing, snooze_cnt);
        end
    endtask
`else
    task automatic test_snooze();
        start_ring();
        snooze = 1'b1;
        step(1'b0);
        snooze = 1'b0;
        checks++;
        if (ring !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL snooze_ignored: got ring=%b snoozing=%b cnt=%0d expected 1 0 0",
                     ring, snoozing, snooze_cnt);
        end
        stop_ring();
    endtask
`endif

    task automatic test_stop_and_snooze();
        start_ring();
        stop   = 1'b1;
        snooze = 1'b1;
        step(1'b1);
        stop   = 1'b0;
        snooze = 1'b0;
        checks++;
        if (ring !== 1'b0 || snoozing !== 1'b0 || snooze_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stop_and_snooze: got ring=%b snoozing=%b cnt=%0d expected 0 0 0",
                     ring, snoozing, snooze_cnt);
        end
    endtask

    task automatic test_clr_midring();
        start_ring();
        #2;
        CLR = 1'b0;
        #1;
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_async: got %b expected 0", ring);
        end
        @(posedge Clk);
        #1;
        CLR = 1'b1;
        step(1'b0);
        checks++;
        if (ring !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_release: got %b expected 0", ring);
        end
        set_time(7, 30, 0);
        step(1'b1);
        checks++;
        if (ring !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ring_after_clr: got %b expected 1", ring);
        end
        stop_ring();
    endtask

    initial begin
        test_reset();
        test_match();
        test_day();
        test_autostop();
        test_snooze();
        test_stop_and_snooze();
        test_clr_midring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_reader.md
# alarm_reader

Read side of the weekly alarm store: each second it selects the stored alarm word for the current day from the seven day registers, compares it against the running time of day, and drives the ringer. It also runs ring-timeout and snooze sequencing. It sits between the alarm register bank and the buzzer/display logic, with the time-keeping counters as its other input.

## Interface
Parameters:
- RING_SECS, 60: seconds a ring lasts before auto-stop (1..255)
- SNOOZE_SECS, 300: seconds spent in snooze before re-ringing (1..1023)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..3)

Ports:
- Clk  input  1  system clock, rising edge
- CLR  input  1  asynchronous active-low clear
- Q_r0..Q_r6  input  13 each  stored alarm words, Sunday..Saturday
  - [12] armed
  - [11] ignored
  - [10:6] hour 0-23
  - [5:0] minute 0-59
- day  input  3  current day, 0=Sunday..6=Saturday; 7 = invalid
- cur_hour  input  5  current hour
- cur_min  input  6  current minute
- cur_sec  input  6  current second
- sec_tick  input  1  one-cycle pulse, once per second, time inputs stable in that cycle
- stop  input  1  level, sampled each cycle
- snooze  input  1  level, sampled each cycle
- ring  output  1  buzzer drive
- snoozing  output  1  high while in SNOOZE
- snooze_cnt  output  2  snoozes used in current event

## Operation
- FSM states IDLE, RINGING, SNOOZE. Reset: IDLE, ring=0, snoozing=0, snooze_cnt=0, all internal counters 0.
- Match condition, evaluated only in IDLE and only in a sec_tick cycle:
  - selected word (by day) has armed=1;
  - hour equals cur_hour and minute equals cur_min;
  - cur_sec==0.
  - day==7 never matches.
- IDLE -> RINGING on match. Second counter cleared, snooze_cnt cleared.
- RINGING, evaluated in priority order each cycle:
  - stop=1 -> IDLE, snooze_cnt cleared.
  - snooze=1 and snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, second counter cleared.
  - snooze=1 and snooze_cnt==MAX_SNOOZE -> treated as stop.
  - Otherwise, each sec_tick increments the second counter; when it reaches RING_SECS -> IDLE, snooze_cnt cleared.
- SNOOZE:
  - stop=1 -> IDLE, snooze_cnt cleared.
  - snooze ignored.
  - Each sec_tick increments the second counter; at SNOOZE_SECS -> RINGING, second counter cleared.
- Match evaluation is suppressed in RINGING and SNOOZE. Changes to day or register contents during an event have no effect on it.
- stop and snooze both high: stop wins.
- Counters are sized for the maximum parameter values and never wrap in legal operation.

## Timing
- Outputs are registered and decoded from state only:
  - ring=1 exactly in RINGING;
  - snoozing=1 exactly in SNOOZE.
- Match in sec_tick cycle N -> ring=1 from cycle N+1.
- stop or snooze at cycle N -> ring=0 at N+1; snoozing=1 at N+1 on a snooze.
- Auto-stop: ring falls the cycle after the RING_SECS-th sec_tick counted in RINGING.
- Snooze expiry: ring rises the cycle after the SNOOZE_SECS-th sec_tick counted in SNOOZE.
- snooze_cnt updates in the same edge as the state change.
- CLR low at any time, including mid-ring or mid-snooze: all outputs 0 immediately, with no clock required. Operation restarts from IDLE after CLR rises.
- A sec_tick coinciding with a stop: stop wins, no count.

## Configuration
- ALARM_SNOOZE_EN defined:
  - snooze behaviour as described;
  - snoozing and snooze_cnt live.
- ALARM_SNOOZE_EN not defined:
  - SNOOZE state, snooze counter and snooze logic are compiled out;
  - snooze input ignored;
  - snoozing and snooze_cnt tied to 0;
  - a ring ends only on stop, auto-stop or CLR.

## Test plan
- Q_r2=13'h1000|(7<<6)|30, day=2, time 07:30:00, sec_tick -> ring=1 next cycle. Same word with armed=0 -> ring stays 0.
- Match on Q_r2 but day=3 or day=7 -> no ring. Q_r3 programmed and day=3 -> ring.
- Ringing with RING_SECS=60 and no input -> ring falls after the 60th counted sec_tick, with no re-trigger at 07:31:00.
- Ringing, snooze pulse -> snoozing=1, snooze_cnt=1. After SNOOZE_SECS ticks -> ring=1. Fourth snooze with MAX_SNOOZE=3 -> IDLE, snooze_cnt=0.
- stop and snooze asserted together while ringing -> IDLE, snoozing=0, snooze_cnt=0.
- CLR low mid-ring, between clock edges -> ring=0 immediately. After release, the next matching sec_tick rings again.
